// File: rtl/irq_sequencer_pkg.sv
// Shared encodings for the interrupt sequencer: FSM states, next-PC select codes,
// the default vector base and the handler-address helper.
package irq_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TAKE    = 2'd1,
        ST_SERVICE = 2'd2,
        ST_RETURN  = 2'd3
    } irq_state_e;

    localparam logic [2:0] NPC_PLUS4  = 3'b000;
    localparam logic [2:0] NPC_BRANCH = 3'b001;
    localparam logic [2:0] NPC_JUMP   = 3'b010;
    localparam logic [2:0] NPC_JALR   = 3'b011;
    localparam logic [2:0] NPC_INT    = 3'b101;
    localparam logic [2:0] NPC_EPC    = 3'b110;

    localparam logic [31:0] IRQ_VEC_BASE = 32'h0000_0100;

    // Handler address; 32-bit result so the sum wraps modulo 2^32.
    function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                             input logic [31:0] stride,
                                             input logic [2:0]  id);
        return base + 32'(id) * stride;
    endfunction

endpackage

// File: rtl/irq_sequencer_if.sv
// Pipeline-side bundle of the interrupt sequencer; mask write port present only
// when IRQ_MASK_EN is defined.
interface irq_sequencer_if #(
    parameter int NUM_IRQ = 4
);
    logic [NUM_IRQ-1:0] irq;
    logic               int_finished;
    logic               id_valid;
    logic [31:0]        id_pc;
    logic               pipe_stall;
    logic               int_flush;
    logic               npc_int;
    logic               npc_epc;
    logic [31:0]        int_vector;
    logic [31:0]        epc;
    logic               in_service;
    logic [2:0]         active_id;
    logic [NUM_IRQ-1:0] pending;
`ifdef IRQ_MASK_EN
    logic               mask_we;
    logic [NUM_IRQ-1:0] mask_wdata;

    modport master (
        output irq, int_finished, id_valid, id_pc, pipe_stall, mask_we, mask_wdata,
        input  int_flush, npc_int, npc_epc, int_vector, epc, in_service, active_id, pending
    );
    modport slave (
        input  irq, int_finished, id_valid, id_pc, pipe_stall, mask_we, mask_wdata,
        output int_flush, npc_int, npc_epc, int_vector, epc, in_service, active_id, pending
    );
`else
    modport master (
        output irq, int_finished, id_valid, id_pc, pipe_stall,
        input  int_flush, npc_int, npc_epc, int_vector, epc, in_service, active_id, pending
    );
    modport slave (
        input  irq, int_finished, id_valid, id_pc, pipe_stall,
        output int_flush, npc_int, npc_epc, int_vector, epc, in_service, active_id, pending
    );
`endif
endinterface

// File: rtl/irq_sync_edge.sv
// One interrupt line: 2-flop synchronizer followed by a rising-edge detector.
// Detection is held off until the history flop holds a real post-reset sample.
module irq_sync_edge (
    input  logic clk,
    input  logic rstn,
    input  logic line,
    output logic rise
);
    logic       sync_p0;
    logic       sync_p1;
    logic       hist_p2;
    logic [2:0] arm;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            hist_p2 <= 1'b0;
            arm     <= 3'b000;
        end else begin
            sync_p0 <= line;
            sync_p1 <= sync_p0;
            hist_p2 <= sync_p1;
            arm     <= {arm[1:0], 1'b1};
        end
    end

    // A line already high at reset release never looks like a fresh edge.
    assign rise = sync_p1 & ~hist_p2 & arm[2];

endmodule

// File: rtl/irq_sequencer.sv
// Interrupt sequencer: latches edge-detected lines, takes the lowest pending one,
// redirects the pipeline to its vector and back to epc on mret. Option: IRQ_MASK_EN.
module irq_sequencer
    import irq_sequencer_pkg::*;
#(
    parameter int          NUM_IRQ    = 4,
    parameter logic [31:0] VEC_BASE   = IRQ_VEC_BASE,
    parameter logic [31:0] VEC_STRIDE = 32'h4
) (
    input logic            clk,
    input logic            rstn,
    irq_sequencer_if.slave bus
);
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] pending_q;
    logic [NUM_IRQ-1:0] enabled;
    logic [NUM_IRQ-1:0] clear_vec;
    logic               winner_found;
    logic [2:0]         winner_id;
    logic               take;
    irq_state_e         state_q;
    irq_state_e         state_d;
    logic [31:0]        epc_q;
    logic [2:0]         active_id_q;
    logic [2:0]         npc_code;

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_line
        irq_sync_edge u_sync (
            .clk  (clk),
            .rstn (rstn),
            .line (bus.irq[g]),
            .rise (rise[g])
        );
    end

`ifdef IRQ_MASK_EN
    logic [NUM_IRQ-1:0] mask_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)            mask_q <= '1;
        else if (bus.mask_we) mask_q <= bus.mask_wdata;
    end

    // Masked lines keep their pending bit; they just do not compete.
    assign enabled = pending_q & mask_q;
`else
    assign enabled = pending_q;
`endif

    always_comb begin
        winner_found = 1'b0;
        winner_id    = 3'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (enabled[i]) begin
                winner_found = 1'b1;
                winner_id    = 3'(i);
            end
        end
    end

    assign take = (state_q == ST_IDLE) && winner_found && bus.id_valid && !bus.pipe_stall;

    always_comb begin
        clear_vec = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (take && (winner_id == 3'(i))) clear_vec[i] = 1'b1;
        end
    end

    // A fresh edge on the winner in its clear cycle re-arms it (set wins).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending_q   <= '0;
            epc_q       <= '0;
            active_id_q <= '0;
        end else begin
            pending_q <= (pending_q & ~clear_vec) | rise;
            if (take) begin
                epc_q       <= bus.id_pc;
                active_id_q <= winner_id;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (take) state_d = ST_TAKE;
            ST_TAKE:    state_d = ST_SERVICE;
            ST_SERVICE: if (bus.int_finished && !bus.pipe_stall) state_d = ST_RETURN;
            ST_RETURN:  state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        npc_code = NPC_PLUS4;
        case (state_q)
            ST_TAKE:   npc_code = NPC_INT;
            ST_RETURN: npc_code = NPC_EPC;
            default:   npc_code = NPC_PLUS4;
        endcase
        bus.npc_int    = (npc_code == NPC_INT);
        bus.npc_epc    = (npc_code == NPC_EPC);
        bus.int_flush  = (npc_code == NPC_INT) || (npc_code == NPC_EPC);
        bus.in_service = (state_q != ST_IDLE);
    end

    assign bus.int_vector = vec_addr(VEC_BASE, VEC_STRIDE, active_id_q);
    assign bus.epc        = epc_q;
    assign bus.active_id  = active_id_q;
    assign bus.pending    = pending_q;

endmodule

// File: tb/tb_irq_sequencer.sv
// Bench for irq_sequencer: directed scenarios then randomized traffic, all checked
// against a behavioural model of the sequencing rules.
module tb_irq_sequencer;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rstn;

    irq_sequencer_if #(.NUM_IRQ(N)) bus ();

    irq_sequencer #(
        .NUM_IRQ    (N),
        .VEC_BASE   (32'h0000_0100),
        .VEC_STRIDE (32'h4)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: samples of each line since reset, latched requests, handler phase.
    logic [N-1:0] h0, h1, h2;
    int           nsamp;
    logic [N-1:0] m_pend;
    logic [N-1:0] m_mask;
    int           phase;   // 0 idle, 1 take, 2 handler, 3 return
    logic [31:0]  m_epc;
    logic [2:0]   m_id;

    task automatic model_reset();
        h0 = '0; h1 = '0; h2 = '0; nsamp = 0;
        m_pend = '0; m_mask = '1; phase = 0; m_epc = '0; m_id = '0;
    endtask

    task automatic model_clock();
        logic [N-1:0] rise;
        int           w;
        bit           tk;
        nsamp++;
        // Request seen when the line was high two samples ago and low three ago.
        rise = (nsamp >= 4) ? (h1 & ~h2) : '0;
        h2 = h1; h1 = h0; h0 = bus.irq;
        w = -1;
        for (int i = N - 1; i >= 0; i--) if (m_pend[i] && m_mask[i]) w = i;
        tk = (phase == 0) && (w >= 0) && bus.id_valid && !bus.pipe_stall;
        if (tk) m_pend[w] = 1'b0;
        m_pend = m_pend | rise;
        case (phase)
            0: if (tk) begin phase = 1; m_epc = bus.id_pc; m_id = 3'(w); end
            1: phase = 2;
            2: if (bus.int_finished && !bus.pipe_stall) phase = 3;
            default: phase = 0;
        endcase
`ifdef IRQ_MASK_EN
        if (bus.mask_we) m_mask = bus.mask_wdata;
`endif
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("int_flush",  32'(bus.int_flush),  32'(phase == 1 || phase == 3));
        check("npc_int",    32'(bus.npc_int),    32'(phase == 1));
        check("npc_epc",    32'(bus.npc_epc),    32'(phase == 3));
        check("in_service", 32'(bus.in_service), 32'(phase != 0));
        check("epc",        bus.epc,             m_epc);
        check("active_id",  32'(bus.active_id),  32'(m_id));
        check("int_vector", bus.int_vector,      32'h100 + 32'(m_id) * 32'h4);
        check("pending",    32'(bus.pending),    32'(m_pend));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_clock();
        #1;
        check_all();
    endtask

    task automatic mret();
        bus.int_finished = 1'b1;
        cycle();
        bus.int_finished = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        bus.irq = '0; bus.int_finished = 1'b0; bus.id_valid = 1'b0;
        bus.id_pc = '0; bus.pipe_stall = 1'b0;
`ifdef IRQ_MASK_EN
        bus.mask_we = 1'b0; bus.mask_wdata = '1;
`endif
        model_reset();
        #12;
        check_all();
        check("rst_vector", bus.int_vector, 32'h100);
        @(negedge clk);
        rstn = 1'b1;
        repeat (6) cycle();

        // Single line: edge to pending in 3 clocks, take on the next.
        bus.id_valid = 1'b1; bus.id_pc = 32'h40; bus.irq = 4'b0100;
        repeat (3) cycle();
        check("t1_pending", 32'(bus.pending), 32'h4);
        check("t1_noflush", 32'(bus.int_flush), 32'h0);
        cycle();
        check("t1_flush",  32'(bus.int_flush), 32'h1);
        check("t1_npcint", 32'(bus.npc_int), 32'h1);
        check("t1_vector", bus.int_vector, 32'h108);
        check("t1_epc",    bus.epc, 32'h40);
        bus.id_pc = 32'h80;
        cycle();
        check("t1_service", 32'(bus.in_service), 32'h1);
        mret();
        check("t1_npcepc",  32'(bus.npc_epc), 32'h1);
        check("t1_ret_epc", bus.epc, 32'h40);
        cycle();
        check("t1_idle", 32'(bus.in_service), 32'h0);
        mret();
        check("idle_mret_npcepc", 32'(bus.npc_epc), 32'h0);
        check("idle_mret_state",  32'(bus.in_service), 32'h0);

        // Two lines together: lowest index first, the other after return.
        bus.irq = 4'b1010;
        repeat (3) cycle();
        check("t2_pending", 32'(bus.pending), 32'hA);
        cycle();
        check("t2_vec1", bus.int_vector, 32'h104);
        cycle();
        check("t2_pend3", 32'(bus.pending), 32'h8);
        mret();
        cycle();
        cycle();
        check("t2_vec3", bus.int_vector, 32'h10C);
        check("t2_flush3", 32'(bus.int_flush), 32'h1);
        cycle();
        mret();
        cycle();

        // Stall holds off the take until it drops.
        bus.irq = '0;
        repeat (4) cycle();
        bus.pipe_stall = 1'b1; bus.irq = 4'b0001;
        repeat (3) cycle();
        check("t3_pending", 32'(bus.pending), 32'h1);
        repeat (5) begin
            cycle();
            check("t3_stall_noflush", 32'(bus.int_flush), 32'h0);
        end
        bus.pipe_stall = 1'b0;
        cycle();
        check("t3_take", 32'(bus.int_flush), 32'h1);
        check("t3_vec0", bus.int_vector, 32'h100);
        cycle();
        mret();
        cycle();

        // Reset during the handler abandons it; lines high at release stay quiet.
        bus.irq = 4'b1100;
        repeat (5) cycle();
        check("t4_service", 32'(bus.in_service), 32'h1);
        check("t4_pend3",   32'(bus.pending), 32'h8);
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        check("t4_rst_service", 32'(bus.in_service), 32'h0);
        check("t4_rst_pending", 32'(bus.pending), 32'h0);
        check("t4_rst_flush",   32'(bus.int_flush), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        repeat (8) begin
            cycle();
            check("t4_quiet_pending", 32'(bus.pending), 32'h0);
            check("t4_quiet_flush",   32'(bus.int_flush), 32'h0);
        end

`ifdef IRQ_MASK_EN
        // Masked line latches but is not taken until re-enabled.
        bus.irq = '0;
        repeat (4) cycle();
        bus.mask_we = 1'b1; bus.mask_wdata = 4'b1110;
        cycle();
        bus.mask_we = 1'b0;
        bus.irq = 4'b0001;
        repeat (3) cycle();
        check("t5_pending", 32'(bus.pending), 32'h1);
        repeat (6) begin
            cycle();
            check("t5_masked", 32'(bus.in_service), 32'h0);
        end
        bus.mask_we = 1'b1; bus.mask_wdata = 4'b1111;
        cycle();
        bus.mask_we = 1'b0;
        cycle();
        check("t5_take", 32'(bus.int_flush), 32'h1);
        check("t5_vec0", bus.int_vector, 32'h100);
        cycle();
        mret();
        cycle();
`endif

        // Randomized traffic.
        for (int k = 0; k < 2000; k++) begin
            for (int b = 0; b < N; b++) if ($urandom_range(0, 9) == 0) bus.irq[b] = ~bus.irq[b];
            bus.id_valid     = ($urandom_range(0, 3) != 0);
            bus.pipe_stall   = ($urandom_range(0, 3) == 0);
            bus.int_finished = ($urandom_range(0, 7) == 0);
            bus.id_pc        = $urandom & 32'hFFFF_FFFC;
`ifdef IRQ_MASK_EN
            bus.mask_we      = ($urandom_range(0, 31) == 0);
            bus.mask_wdata   = N'($urandom);
`endif
            cycle();
            check("rnd_excl", 32'(bus.npc_int & bus.npc_epc), 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
